// File: rtl/hdmi_pkg.sv
// Shared definitions for the HDMI transmit controller: FSM encodings,
// TMDS control tokens and lane geometry.
package hdmi_pkg;

  localparam int unsigned LANE_W    = 10;
  localparam int unsigned NUM_LANES = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_HOLD_RST  = 3'd2,
    ST_PREAMBLE  = 3'd3,
    ST_ACTIVE    = 3'd4
  } state_t;

  // TMDS control-period tokens for {C1,C0} = 00, 01, 10, 11
  localparam logic [LANE_W-1:0] CTRL_TOKEN_0 = 10'b1101010100;
  localparam logic [LANE_W-1:0] CTRL_TOKEN_1 = 10'b0010101011;
  localparam logic [LANE_W-1:0] CTRL_TOKEN_2 = 10'b0101010100;
  localparam logic [LANE_W-1:0] CTRL_TOKEN_3 = 10'b1010101011;

endpackage

// File: rtl/hdmi_lanerot.sv
// Per-lane registered word rotator with a mod-10 bit-slip counter.
// Rotation by r yields {w[r-1:0], w[9:r]}; the slip takes effect on the following word.
module hdmi_lanerot
  import hdmi_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_slip,
  input  logic [LANE_W-1:0] i_word,
  output logic [LANE_W-1:0] o_word
);

  logic [3:0]        rot_q, rot_d;
  logic [LANE_W-1:0] word_q, word_d;

  always_comb begin
    rot_d = rot_q;
    if (i_slip) begin
      rot_d = (rot_q == 4'd9) ? '0 : rot_q + 4'd1;
    end
  end

  always_comb begin
    logic [4:0] idx;
    word_d = '0;
    for (int unsigned i = 0; i < LANE_W; i++) begin
      idx = 5'(i) + {1'b0, rot_q};
      if (idx >= 5'd10) begin
        idx = idx - 5'd10;
      end
      word_d[i] = i_word[idx[3:0]];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      rot_q  <= '0;
      word_q <= '0;
    end else begin
      rot_q  <= rot_d;
      word_q <= word_d;
    end
  end

  assign o_word = word_q;

endmodule

// File: rtl/hdmi_txctrl.sv
// HDMI transmit bring-up controller: waits for PLL lock, holds the serializers
// in reset, sends a control-token preamble, then forwards pixel words.
module hdmi_txctrl
  import hdmi_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES     = 1024,
  parameter int unsigned RST_CYCLES      = 16,
  parameter int unsigned PREAMBLE_CYCLES = 64
) (
  input  logic                          i_clk,
  input  logic                          i_reset,
  input  logic                          i_en,
  input  logic                          i_pll_locked,
  input  logic [NUM_LANES*LANE_W-1:0]   i_word,
  input  logic [NUM_LANES-1:0]          i_slip,
  output logic                          o_ce,
  output logic [NUM_LANES*LANE_W-1:0]   o_word,
  output logic                          o_active,
  output logic                          o_lock_err,
  output logic [2:0]                    o_state
);

  localparam int unsigned LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam int unsigned RST_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int unsigned PRE_W  = (PREAMBLE_CYCLES > 1) ? $clog2(PREAMBLE_CYCLES) : 1;

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYCLES - 1);
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(PREAMBLE_CYCLES - 1);

  state_t              state_q, state_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic [RST_W-1:0]    rst_cnt_q, rst_cnt_d;
  logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
  logic                lock_err_q, lock_err_d;
  logic [NUM_LANES*LANE_W-1:0] lane_in;

  // Counters default to zero so any state change restarts them.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = '0;
    rst_cnt_d  = '0;
    pre_cnt_d  = '0;
    lock_err_d = lock_err_q;
    if (!i_en) begin
      state_d    = ST_IDLE;
      lock_err_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_WAIT_LOCK;
        ST_WAIT_LOCK: begin
          if (i_pll_locked) begin
            if (lock_cnt_q == LOCK_LAST) state_d = ST_HOLD_RST;
            else lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
        ST_HOLD_RST, ST_PREAMBLE, ST_ACTIVE: begin
          if (!i_pll_locked) begin
            state_d    = ST_WAIT_LOCK;
            lock_err_d = 1'b1;
          end else if (state_q == ST_HOLD_RST) begin
            if (rst_cnt_q == RST_LAST) state_d = ST_PREAMBLE;
            else rst_cnt_d = rst_cnt_q + 1'b1;
          end else if (state_q == ST_PREAMBLE) begin
            if (pre_cnt_q == PRE_LAST) state_d = ST_ACTIVE;
            else pre_cnt_d = pre_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= ST_IDLE;
      lock_cnt_q <= '0;
      rst_cnt_q  <= '0;
      pre_cnt_q  <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
      rst_cnt_q  <= rst_cnt_d;
      pre_cnt_q  <= pre_cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  // Lane source keyed on the next state so the registered word lines up with state_q.
  always_comb begin
    lane_in = '0;
    if (state_d == ST_PREAMBLE) lane_in = {NUM_LANES{CTRL_TOKEN_0}};
    else if (state_d == ST_ACTIVE) lane_in = i_word;
  end

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hdmi_lanerot u_rot (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_slip  (i_slip[l]),
      .i_word  (lane_in[l*LANE_W +: LANE_W]),
      .o_word  (o_word[l*LANE_W +: LANE_W])
    );
  end

  assign o_ce       = (state_q == ST_PREAMBLE) || (state_q == ST_ACTIVE);
  assign o_active   = (state_q == ST_ACTIVE);
  assign o_lock_err = lock_err_q;
  assign o_state    = state_q;

endmodule
